// File: rtl/simmem_write_resp_bank.sv
// rtl/simmem_write_resp_bank.sv - write response bank: per-ID linked-list FIFOs in a shared slot RAM
//
// Holds write responses returned by the real memory until the per-ID delay
// logic enables their release. All IDs share one pool of TotalCapacity slots;
// each ID keeps its own singly linked list (head, tail, length) so responses
// of one ID leave in arrival order while different IDs are released
// independently, lowest enabled ID first.
//
// Ports:
//   clk_i         clock
//   rst_i         asynchronous active-high reset
//   in_data_i     response from real memory, ID in the top IDWidth bits
//   in_valid_i    input valid
//   in_ready_o    at least one free slot
//   release_en_i  bit i set: head response of ID i may be emitted
//   out_data_o    released response (0 when nothing is offered)
//   out_valid_o   a response is offered
//   out_ready_i   downstream ready
//   occupancy_o   stored response count (only with SIMMEM_WRITE_RESP_BANK_OCCUPANCY_EN)
//
// Build option: define SIMMEM_WRITE_RESP_BANK_OCCUPANCY_EN to add occupancy_o.

module simmem_write_resp_bank #(
    parameter int TotalCapacity = 32,
    parameter int IDWidth       = 4,
    parameter int DataWidth     = 7,
    localparam int AddrWidth    = $clog2(TotalCapacity),
    localparam int NumIds       = 2 ** IDWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DataWidth-1:0] in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [NumIds-1:0]    release_en_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i
`ifdef SIMMEM_WRITE_RESP_BANK_OCCUPANCY_EN
    ,
    output logic [AddrWidth:0]   occupancy_o
`endif
);

    localparam logic [AddrWidth:0] LenOne = (AddrWidth + 1)'(1);

    // Slot storage: payload and the link to the next slot of the same ID.
    logic [DataWidth-1:0] payload_q [TotalCapacity];
    logic [AddrWidth-1:0] nxt_q     [TotalCapacity];
    logic [TotalCapacity-1:0] free_q;

    // Per-ID list descriptors.
    logic [AddrWidth-1:0] head_q [NumIds];
    logic [AddrWidth-1:0] tail_q [NumIds];
    logic [AddrWidth:0]   len_q  [NumIds];

    logic [AddrWidth-1:0] free_slot;
    logic [IDWidth-1:0]   push_id;
    logic [IDWidth-1:0]   sel_id;
    logic                 sel_valid;
    logic [AddrWidth-1:0] pop_slot;
    logic                 push;
    logic                 pop;
    logic                 head_restart;

    // Lowest-index free slot. The bitmap is registered, so a slot freed by a
    // pop this cycle is only visible to pushes from the next cycle on.
    always_comb begin
        free_slot = '0;
        for (int i = TotalCapacity - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                free_slot = AddrWidth'(i);
            end
        end
    end

    // Lowest non-empty, enabled ID wins the output.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        for (int i = NumIds - 1; i >= 0; i--) begin
            if ((len_q[i] != '0) && release_en_i[i]) begin
                sel_valid = 1'b1;
                sel_id    = IDWidth'(i);
            end
        end
    end

    assign in_ready_o  = |free_q;
    assign push_id     = in_data_i[DataWidth-1 -: IDWidth];
    assign push        = in_valid_i & in_ready_o;
    assign pop_slot    = head_q[sel_id];
    assign pop         = sel_valid & out_ready_i;
    assign out_valid_o = sel_valid;
    assign out_data_o  = sel_valid ? payload_q[pop_slot] : '0;

    // A push starts a fresh list when the ID is empty, or when its only
    // element leaves in the same cycle; the new slot then becomes the head
    // and the stale tail must not be linked.
    assign head_restart = (len_q[push_id] == '0) ||
                          ((len_q[push_id] == LenOne) && pop && (sel_id == push_id));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            free_q <= '1;
            for (int i = 0; i < NumIds; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else begin
            if (pop) begin
                free_q[pop_slot] <= 1'b1;
                head_q[sel_id]   <= nxt_q[pop_slot];
            end
            // Pushes come after pops so a restart overrides the pop's head advance.
            if (push) begin
                free_q[free_slot] <= 1'b0;
                tail_q[push_id]   <= free_slot;
                if (head_restart) begin
                    head_q[push_id] <= free_slot;
                end
            end
            for (int i = 0; i < NumIds; i++) begin
                if ((push && (push_id == IDWidth'(i))) && !(pop && (sel_id == IDWidth'(i)))) begin
                    len_q[i] <= len_q[i] + LenOne;
                end else if (!(push && (push_id == IDWidth'(i))) && (pop && (sel_id == IDWidth'(i)))) begin
                    len_q[i] <= len_q[i] - LenOne;
                end
            end
        end
    end

    // Slot RAM is not reset; only slots reachable from a live list are read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            payload_q[free_slot] <= in_data_i;
            if (!head_restart) begin
                nxt_q[tail_q[push_id]] <= free_slot;
            end
        end
    end

`ifdef SIMMEM_WRITE_RESP_BANK_OCCUPANCY_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occupancy_o <= '0;
        end else if (push && !pop) begin
            occupancy_o <= occupancy_o + LenOne;
        end else if (pop && !push) begin
            occupancy_o <= occupancy_o - LenOne;
        end
    end

    occupancy_bound_a : assert property (
        @(posedge clk_i) disable iff (rst_i)
        occupancy_o <= (AddrWidth + 1)'(TotalCapacity)
    );
`else
    // No occupancy tracking in this build.
`endif

endmodule
